chacha_keystream_xor: RTL and testbench

Downstream consumer of the ChaCha20 block core. Requests one 512-bit keystream block from the core, buffers it, and XORs it word-by-word (32-bit, little-endian) into a valid/ready message stream. The result is a ciphertext/plaintext output stream. A new block is fetched lazily, only when buffered keystream is exhausted and message data is pending.

---
 rtl/chacha_keystream_xor.sv | 141 ++++++++++++++
 tb/tb_chacha_keystream_xor.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/chacha_keystream_xor.sv
// Keystream consumer for the ChaCha20 block core: fetches one 512-bit block on demand
// and XORs it word-by-word into a valid/ready message stream.
module chacha_keystream_xor #(
    parameter int WORDS = 16,
    parameter int CNT_W = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    output logic                  blk_start_o,
    input  logic                  blk_ready_i,
    input  logic                  blk_done_i,
    input  logic [32*WORDS-1:0]   blk_keystream_i,
    input  logic                  msg_valid_i,
    output logic                  msg_ready_o,
    input  logic [31:0]           msg_data_i,
    input  logic [3:0]            msg_keep_i,
    input  logic                  msg_last_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [31:0]           out_data_o,
    output logic [3:0]            out_keep_o,
    output logic                  out_last_o,
    output logic [CNT_W-1:0]      blk_cnt_o
);

    localparam int IDX_W = $clog2(WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_STREAM
    } state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [32*WORDS-1:0] ks_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                accept;
    logic                capture;
    logic [31:0]         ks_word;
    logic [31:0]         xor_data;

    // Input is only taken while streaming and the output register can make room this cycle.
    assign msg_ready_o = (state_q == ST_STREAM) && (!out_valid_o || out_ready_i);
    assign accept      = msg_valid_i && msg_ready_o;
    assign capture     = (state_q == ST_WAIT) && blk_done_i;
    assign ks_word     = ks_q[32*idx_q +: 32];
    assign blk_cnt_o   = cnt_q;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        xor_data = '0;
        for (int j = 0; j < 4; j++) begin
            if (msg_keep_i[j]) begin
                xor_data[8*j +: 8] = msg_data_i[8*j +: 8] ^ ks_word[8*j +: 8];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        blk_start_o = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (msg_valid_i) begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                blk_start_o = blk_ready_i;
                if (blk_ready_i) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (blk_done_i) begin
                    idx_d   = '0;
                    state_d = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (accept) begin
                    // Leftover keystream is dropped at message end so each message starts on a fresh block.
                    if (idx_q == LAST_IDX || msg_last_i) begin
                        idx_d   = '0;
                        state_d = ST_IDLE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: sequential state is written with non-blocking assignments only.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            if (state_q == ST_REQ && blk_ready_i) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    // NOTE: the keystream buffer is reset so no stale key material survives a reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ks_q <= '0;
        end else if (capture) begin
            ks_q <= blk_keystream_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_valid_o <= 1'b0;
            out_data_o  <= '0;
            out_keep_o  <= '0;
            out_last_o  <= 1'b0;
        end else if (accept) begin
            out_valid_o <= 1'b1;
            out_data_o  <= xor_data;
            out_keep_o  <= msg_keep_i;
            out_last_o  <= msg_last_i;
        end else if (out_ready_i) begin
            out_valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_chacha_keystream_xor.sv
// Scoreboard bench for chacha_keystream_xor: behavioural block core, directed message
// vectors, and a monitor that checks every output beat against queued expectations.
module tb_chacha_keystream_xor;

    localparam int CNT_W = 32;

    logic             clk_i = 1'b0;
    logic             rst_ni = 1'b0;
    logic             blk_start_o;
    logic             blk_ready_i;
    logic             blk_done_i;
    logic [511:0]     blk_keystream_i;
    logic             msg_valid_i = 1'b0;
    logic             msg_ready_o;
    logic [31:0]      msg_data_i = '0;
    logic [3:0]       msg_keep_i = '0;
    logic             msg_last_i = 1'b0;
    logic             out_valid_o;
    logic             out_ready_i = 1'b1;
    logic [31:0]      out_data_o;
    logic [3:0]       out_keep_o;
    logic             out_last_o;
    logic [CNT_W-1:0] blk_cnt_o;

    logic         core_done = 1'b0;
    logic         spur_done = 1'b0;
    logic         core_avail = 1'b1;
    logic [511:0] core_ks = '0;

    assign blk_ready_i     = core_avail;
    assign blk_done_i      = core_done | spur_done;
    assign blk_keystream_i = spur_done ? {16{32'hDEADBEEF}} : core_ks;

    always #5 clk_i = ~clk_i;

    chacha_keystream_xor #(.WORDS(16), .CNT_W(CNT_W)) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .blk_start_o     (blk_start_o),
        .blk_ready_i     (blk_ready_i),
        .blk_done_i      (blk_done_i),
        .blk_keystream_i (blk_keystream_i),
        .msg_valid_i     (msg_valid_i),
        .msg_ready_o     (msg_ready_o),
        .msg_data_i      (msg_data_i),
        .msg_keep_i      (msg_keep_i),
        .msg_last_i      (msg_last_i),
        .out_valid_o     (out_valid_o),
        .out_ready_i     (out_ready_i),
        .out_data_o      (out_data_o),
        .out_keep_o      (out_keep_o),
        .out_last_o      (out_last_o),
        .blk_cnt_o       (blk_cnt_o)
    );

    typedef struct packed {
        logic        last;
        logic [3:0]  keep;
        logic [31:0] data;
    } beat_t;

    beat_t       sb[$];
    int          checks = 0;
    int          failures = 0;
    int          srv_cnt = 0;
    int          start_pulses = 0;
    int          busy_viol = 0;
    bit          core_busy = 1'b0;
    int          next_blk = 0;
    int          cur_blk = 0;
    int          idx = 0;
    bit          in_msg = 1'b0;
    logic [31:0] last_exp = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Block 0 follows the byte-counting pattern 00 01 02 ...; later blocks are distinct per id.
    function automatic logic [31:0] ks_word(input int b, input int k);
        if (b == 0) begin
            return 32'h03020100 + 32'h04040404 * 32'(k);
        end
        return (32'h11111111 * 32'(b)) ^ (32'h00010203 * 32'(k));
    endfunction

    function automatic logic [511:0] make_block(input int b);
        logic [511:0] r;
        r = '0;
        for (int k = 0; k < 16; k++) begin
            r[32*k +: 32] = ks_word(b, k);
        end
        return r;
    endfunction

    function automatic logic [31:0] mask(input logic [31:0] d, input logic [3:0] keep);
        logic [31:0] r;
        r = '0;
        for (int j = 0; j < 4; j++) begin
            if (keep[j]) begin
                r[8*j +: 8] = d[8*j +: 8];
            end
        end
        return r;
    endfunction

    // Behavioural block core: serves blocks in order, done one cycle after the start pulse.
    initial begin
        forever begin
            @(posedge clk_i);
            if (blk_start_o === 1'b1) begin
                start_pulses++;
                core_busy = 1'b1;
                @(posedge clk_i);
                #1;
                core_ks   = make_block(srv_cnt);
                srv_cnt++;
                core_done = 1'b1;
                @(posedge clk_i);
                #1;
                core_done = 1'b0;
                core_busy = 1'b0;
            end
        end
    end

    always @(negedge clk_i) begin
        if (core_busy && msg_ready_o === 1'b1) begin
            busy_viol++;
        end
    end

    // Monitor: every handshaked output beat must match the oldest expectation.
    always @(negedge clk_i) begin
        if (rst_ni && out_valid_o === 1'b1 && out_ready_i) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_output actual=%0h expected=none", out_data_o);
            end else begin
                beat_t exp_b;
                beat_t act_b;
                exp_b = sb.pop_front();
                act_b.last = out_last_o;
                act_b.keep = out_keep_o;
                act_b.data = out_data_o;
                check("out_beat", 64'(act_b), 64'(exp_b));
            end
        end
    end

    task automatic send(input logic [31:0] data, input logic [3:0] keep, input logic last,
                        input bit ovr = 1'b0, input logic [31:0] ovr_val = '0);
        int    n;
        beat_t b;
        if (!in_msg) begin
            cur_blk = next_blk;
            next_blk++;
            idx     = 0;
            in_msg  = 1'b1;
        end
        msg_valid_i = 1'b1;
        msg_data_i  = data;
        msg_keep_i  = keep;
        msg_last_i  = last;
        n = 0;
        do begin
            @(negedge clk_i);
            n++;
        end while (msg_ready_o !== 1'b1 && n < 200);
        if (msg_ready_o !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout actual=no_ready expected=ready");
            msg_valid_i = 1'b0;
            return;
        end
        last_exp = ovr ? ovr_val : mask(data ^ ks_word(cur_blk, idx), keep);
        b.last = last;
        b.keep = keep;
        b.data = last_exp;
        sb.push_back(b);
        @(posedge clk_i);
        #1;
        msg_valid_i = 1'b0;
        if (last) begin
            in_msg = 1'b0;
        end else if (idx == 15) begin
            cur_blk = next_blk;
            next_blk++;
            idx = 0;
        end else begin
            idx++;
        end
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk_i);
            n++;
        end
        @(posedge clk_i);
        #1;
        check(name, 64'(sb.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;

        repeat (3) @(posedge clk_i);
        #1;
        check("rst_out_valid", 64'(out_valid_o), 64'd0);
        check("rst_msg_ready", 64'(msg_ready_o), 64'd0);
        check("rst_blk_start", 64'(blk_start_o), 64'd0);
        check("rst_blk_cnt",   64'(blk_cnt_o),   64'd0);
        check("rst_out_data",  64'({out_last_o, out_keep_o, out_data_o}), 64'd0);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;

        // Single word against block 0 word 0 = 0x03020100.
        p0 = start_pulses;
        send(32'hFFFFFFFF, 4'hF, 1'b1, 1'b1, 32'hFCFDFEFF);
        drain("t1_drain");
        check("t1_blk_cnt", 64'(blk_cnt_o), 64'd1);
        check("t1_pulses", 64'(start_pulses - p0), 64'd1);

        // Partial word against keystream 0x11111111.
        send(32'hAABBCCDD, 4'h3, 1'b1, 1'b1, 32'h0000DDCC);
        drain("t2_drain");
        check("t2_blk_cnt", 64'(blk_cnt_o), 64'd2);

        // 20 words span two blocks.
        p0 = start_pulses;
        for (int i = 0; i < 20; i++) begin
            send(32'h5A5A5A5A ^ (32'h01010101 * 32'(i)), 4'hF, (i == 19));
        end
        drain("t3_drain");
        check("t3_pulses", 64'(start_pulses - p0), 64'd2);
        check("t3_blk_cnt", 64'(blk_cnt_o), 64'd4);

        // Backpressure for 5 cycles with a word pending on the input.
        send(32'h10203040, 4'hF, 1'b0);
        send(32'h50607080, 4'hF, 1'b0);
        send(32'h90A0B0C0, 4'hC, 1'b0);
        out_ready_i = 1'b0;
        msg_valid_i = 1'b1;
        msg_data_i  = 32'hCAFEF00D;
        msg_keep_i  = 4'hF;
        msg_last_i  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            check("bp_msg_ready", 64'(msg_ready_o), 64'd0);
            check("bp_hold", 64'({out_valid_o, out_keep_o, out_data_o}), 64'({1'b1, 4'hC, last_exp}));
        end
        @(posedge clk_i);
        #1;
        out_ready_i = 1'b1;
        send(32'hCAFEF00D, 4'hF, 1'b0);
        send(32'h01234567, 4'hF, 1'b0);
        send(32'h89ABCDEF, 4'hF, 1'b1);
        drain("t4_drain");
        check("t4_blk_cnt", 64'(blk_cnt_o), 64'd5);

        // Core not ready for 3 cycles, with a spurious done while requesting.
        p0 = start_pulses;
        core_avail  = 1'b0;
        msg_valid_i = 1'b1;
        msg_data_i  = 32'h0F0F0F0F;
        msg_keep_i  = 4'hF;
        msg_last_i  = 1'b0;
        @(posedge clk_i);
        #1;
        spur_done = 1'b1;
        @(negedge clk_i);
        check("req_start_0", 64'(blk_start_o), 64'd0);
        @(posedge clk_i);
        #1;
        spur_done = 1'b0;
        @(negedge clk_i);
        check("req_start_1", 64'(blk_start_o), 64'd0);
        @(negedge clk_i);
        check("req_start_2", 64'(blk_start_o), 64'd0);
        core_avail = 1'b1;
        #1;
        check("req_start_rise", 64'(blk_start_o), 64'd1);
        send(32'h0F0F0F0F, 4'hF, 1'b0);
        send(32'hFFFFFFFF, 4'h0, 1'b1);
        drain("t5_drain");
        check("t5_pulses", 64'(start_pulses - p0), 64'd1);
        check("t5_blk_cnt", 64'(blk_cnt_o), 64'd6);

        // Reset while streaming at index 7.
        for (int i = 0; i < 7; i++) begin
            send(32'h13579BDF + 32'(i), 4'hF, 1'b0);
        end
        rst_ni = 1'b0;
        #1;
        check("mid_rst_out", 64'({out_valid_o, out_last_o, out_keep_o, out_data_o}), 64'd0);
        check("mid_rst_ready", 64'({msg_ready_o, blk_start_o}), 64'd0);
        check("mid_rst_cnt", 64'(blk_cnt_o), 64'd0);
        sb.delete();
        in_msg = 1'b0;
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        send(32'h2468ACE0, 4'hF, 1'b0);
        send(32'h1357BDF1, 4'h5, 1'b0);
        send(32'h0000FFFF, 4'hF, 1'b1);
        drain("t6_drain");
        check("t6_blk_cnt", 64'(blk_cnt_o), 64'd1);

        check("no_accept_in_wait", 64'(busy_viol), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
